veripac_cpu: RTL

- Parametrised successor of the VeriPac-9 host-mapped trainer core.
- Memory, registers, screen buffer and special registers are mapped into one host address window.
- Adds real instruction execution (fetch/fetch/exec micro-sequencer), free-run and single-step modes, keyboard wait and halt.
- Sits behind the ZX-UNO host bus; the host loads programs, steps or runs them, and reads back state.

---
 rtl/veripac_pkg.sv | 55 +++++
 rtl/veripac_alu.sv | 29 ++
 rtl/veripac_cpu.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/veripac_pkg.sv
// Shared definitions for the VeriPac CPU: opcodes, micro-states, control-block
// offsets and the two-byte instruction predicate.
// Optional feature macro: VERIPAC_CARRY_EN (carry flag and JC instruction).
package veripac_pkg;

   typedef enum logic [1:0] {
      ST_FETCH1 = 2'd0,
      ST_FETCH2 = 2'd1,
      ST_EXEC   = 2'd2,
      ST_HALT   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ALU_PASS = 2'd0,
      ALU_ADD  = 2'd1,
      ALU_SUB  = 2'd2
   } alu_op_t;

   localparam logic [3:0] OP_HLT  = 4'h0;
   localparam logic [3:0] OP_LDA  = 4'h1;
   localparam logic [3:0] OP_STA  = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_LDI  = 4'h5;
   localparam logic [3:0] OP_JMP  = 4'h6;
   localparam logic [3:0] OP_JZ   = 4'h7;
   localparam logic [3:0] OP_LDM  = 4'h8;
   localparam logic [3:0] OP_STM  = 4'h9;
   localparam logic [3:0] OP_KEY  = 4'hA;
   localparam logic [3:0] OP_OUT  = 4'hB;
   localparam logic [3:0] OP_BEEP = 4'hC;
   localparam logic [3:0] OP_CLS  = 4'hD;
   localparam logic [3:0] OP_JC   = 4'hE;

   // Control block offsets relative to RAM_LEN
   localparam logic [2:0] CB_CTRL = 3'd0;
   localparam logic [2:0] CB_KEY  = 3'd1;
   localparam logic [2:0] CB_ACC  = 3'd2;
   localparam logic [2:0] CB_PC   = 3'd3;
   localparam logic [2:0] CB_IR   = 3'd4;
   localparam logic [2:0] CB_DC   = 3'd5;
   localparam int unsigned CB_LEN = 6;

   // Opcodes that pull an operand byte into DC during FETCH2
   function automatic logic is_two_byte(input logic [3:0] op);
`ifdef VERIPAC_CARRY_EN
      return (op == OP_JMP) || (op == OP_JZ) || (op == OP_LDM) ||
             (op == OP_STM) || (op == OP_JC);
`else
      return (op == OP_JMP) || (op == OP_JZ) || (op == OP_LDM) ||
             (op == OP_STM);
`endif
   endfunction

endpackage

// File: rtl/veripac_alu.sv
// Combinational ALU: pass-through, add with carry out, subtract with borrow.
module veripac_alu
   import veripac_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic [DW-1:0] i_a,
   input  logic [DW-1:0] i_b,
   input  logic [1:0]    i_op,
   output logic [DW-1:0] o_res_c,
   output logic          o_carry_c
);

   logic [DW:0] w_sum;

   // One extra bit holds the carry (ADD) or borrow (SUB)
   always_comb begin
      w_sum = '0;
      case (i_op)
         ALU_ADD: w_sum = {1'b0, i_a} + {1'b0, i_b};
         ALU_SUB: w_sum = {1'b0, i_a} - {1'b0, i_b};
         default: w_sum = {1'b0, i_b};
      endcase
   end

   assign o_res_c   = w_sum[DW-1:0];
   assign o_carry_c = w_sum[DW];

endmodule

// File: rtl/veripac_cpu.sv
// VeriPac CPU: host-mapped trainer core with fetch/fetch/exec sequencer,
// free-run and single-step modes, keyboard wait and halt.
// Optional feature macro: VERIPAC_CARRY_EN (carry flag, JC, CTRL bit3).
module veripac_cpu
   import veripac_pkg::*;
#(
   parameter int unsigned DW          = 8,
   parameter int unsigned AW          = 8,
   parameter int unsigned RAM_LEN     = 32'hCA,
   parameter int unsigned SCREEN_BASE = 32'hD0,
   parameter int unsigned SCREEN_LEN  = 32,
   parameter int unsigned REGS_BASE   = 32'hF0,
   parameter int unsigned NUM_REGS    = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] addr,
   input  logic          rd,
   input  logic          wr,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   input  logic          run,
   input  logic          step,
   output logic          halted,
   output logic          key_wanted,
   output logic          buzzer
);

   localparam int unsigned SW = $clog2(SCREEN_LEN);

   state_t        r_state;
   logic [AW-1:0] r_pc;
   logic [AW-1:0] r_dc;
   logic [DW-1:0] r_acc;
   logic [DW-1:0] r_ir;
   logic [DW-1:0] r_kbd;
   logic          r_buzzer;
   logic          r_key_wanted;
   logic          r_key_pressed;
   logic          r_step_q;

   logic [DW-1:0] r_ram    [0:RAM_LEN-1];
   logic [DW-1:0] r_screen [0:SCREEN_LEN-1];
   logic [DW-1:0] r_regs   [0:15];

   logic          w_step_rise;
   logic          w_adv;
   logic          w_exec;
   logic [3:0]    w_op;
   logic [3:0]    w_n;
   logic          w_n_ok;
   logic [DW-1:0] w_reg_val;
   logic [DW-1:0] w_pc_byte;
   logic [DW-1:0] w_dc_byte;
   logic          w_dc_in_ram;
   logic [31:0]   w_addr32;
   logic [31:0]   w_off_cb;
   logic [31:0]   w_off_scr;
   logic [31:0]   w_off_reg;
   logic          w_hit_ram;
   logic          w_hit_cb;
   logic          w_hit_scr;
   logic          w_hit_reg;
   alu_op_t       w_alu_op;
   logic [DW-1:0] w_alu_res;
   logic          w_alu_carry;
   logic          w_carry_flag;

   // Advance gating: host accesses stall the core
   assign w_step_rise = step & ~r_step_q;
   assign w_adv       = (run | w_step_rise) & ~wr & ~rd & ~reset;
   assign w_exec      = w_adv & (r_state == ST_EXEC);

   assign w_op      = r_ir[7:4];
   assign w_n       = r_ir[3:0];
   assign w_n_ok    = 5'(w_n) < 5'(NUM_REGS);
   assign w_reg_val = w_n_ok ? r_regs[w_n] : '0;

   assign w_dc_in_ram = 32'(r_dc) < RAM_LEN;
   assign w_pc_byte   = (32'(r_pc) < RAM_LEN) ? r_ram[r_pc] : '0;
   assign w_dc_byte   = w_dc_in_ram ? r_ram[r_dc] : '0;

   // Window decode: one unsigned compare on the offset covers both bounds
   assign w_addr32  = 32'(addr);
   assign w_off_cb  = w_addr32 - RAM_LEN;
   assign w_off_scr = w_addr32 - SCREEN_BASE;
   assign w_off_reg = w_addr32 - REGS_BASE;
   assign w_hit_ram = w_addr32 < RAM_LEN;
   assign w_hit_cb  = w_off_cb < CB_LEN;
   assign w_hit_scr = w_off_scr < SCREEN_LEN;
   assign w_hit_reg = w_off_reg < NUM_REGS;

   assign w_alu_op = (w_op == OP_ADD) ? ALU_ADD :
                     (w_op == OP_SUB) ? ALU_SUB : ALU_PASS;

   veripac_alu #(.DW(DW)) u_alu (
      .i_a       (r_acc),
      .i_b       (w_reg_val),
      .i_op      (w_alu_op),
      .o_res_c   (w_alu_res),
      .o_carry_c (w_alu_carry)
   );

`ifdef VERIPAC_CARRY_EN
   logic r_carry;
   assign w_carry_flag = r_carry;
`else
   logic w_unused_carry;
   assign w_carry_flag   = 1'b0;
   assign w_unused_carry = w_alu_carry;
`endif

   assign halted     = (r_state == ST_HALT);
   assign key_wanted = r_key_wanted;
   assign buzzer     = r_buzzer;

   // Host read mux; zero when idle or unmapped
   always_comb begin
      dout = '0;
      if (rd) begin
         if (w_hit_ram) begin
            dout = r_ram[addr];
         end else if (w_hit_cb) begin
            case (3'(w_off_cb))
               CB_CTRL: dout = DW'({w_carry_flag, r_buzzer, 2'(r_state)});
               CB_KEY:  dout = DW'(r_key_wanted);
               CB_ACC:  dout = r_acc;
               CB_PC:   dout = DW'(r_pc);
               CB_IR:   dout = r_ir;
               CB_DC:   dout = DW'(r_dc);
               default: dout = '0;
            endcase
         end else if (w_hit_scr) begin
            dout = r_screen[SW'(w_off_scr)];
         end else if (w_hit_reg) begin
            dout = r_regs[4'(w_off_reg)];
         end
      end
   end

   // Storage arrays: host writes and core writes never coincide (adv=0 on wr)
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (wr && w_hit_ram) r_ram[addr] <= din;
         if (wr && w_hit_scr) r_screen[SW'(w_off_scr)] <= din;
         if (wr && w_hit_reg) r_regs[4'(w_off_reg)] <= din;
         if (w_exec && (w_op == OP_STM) && w_dc_in_ram) r_ram[r_dc] <= r_acc;
         if (w_exec && (w_op == OP_STA) && w_n_ok) r_regs[w_n] <= r_acc;
         if (w_exec && (w_op == OP_OUT)) r_screen[r_dc[SW-1:0]] <= w_reg_val;
      end
   end

   // Micro-sequencer, architectural registers and host control-block writes
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_FETCH1;
         r_pc          <= '0;
         r_dc          <= '0;
         r_acc         <= '0;
         r_ir          <= '0;
         r_kbd         <= '0;
         r_buzzer      <= 1'b0;
         r_key_wanted  <= 1'b0;
         r_key_pressed <= 1'b0;
         r_step_q      <= 1'b0;
`ifdef VERIPAC_CARRY_EN
         r_carry       <= 1'b0;
`endif
      end else begin
         r_step_q <= step;
         if (w_adv) begin
            case (r_state)
               ST_FETCH1: begin
                  r_ir    <= w_pc_byte;
                  r_pc    <= r_pc + AW'(1);
                  r_state <= ST_FETCH2;
               end
               ST_FETCH2: begin
                  if (is_two_byte(w_op)) begin
                     r_dc <= AW'(w_pc_byte);
                     r_pc <= r_pc + AW'(1);
                  end
                  r_state <= ST_EXEC;
               end
               ST_EXEC: begin
                  r_state <= ST_FETCH1;
                  case (w_op)
                     OP_HLT:  r_state <= ST_HALT;
                     OP_LDA:  r_acc <= w_alu_res;
                     OP_ADD, OP_SUB: begin
                        r_acc <= w_alu_res;
`ifdef VERIPAC_CARRY_EN
                        r_carry <= w_alu_carry;
`endif
                     end
                     OP_LDI:  r_acc <= DW'(w_n);
                     OP_JMP:  r_pc <= r_dc;
                     OP_JZ:   if (r_acc == '0) r_pc <= r_dc;
                     OP_LDM:  r_acc <= w_dc_byte;
                     OP_KEY: begin
                        if (r_key_pressed) begin
                           r_acc         <= r_kbd;
                           r_key_wanted  <= 1'b0;
                           r_key_pressed <= 1'b0;
                        end else begin
                           r_key_wanted <= 1'b1;
                           r_state      <= ST_EXEC;
                        end
                     end
                     OP_OUT:  r_dc <= r_dc + AW'(1);
                     OP_BEEP: r_buzzer <= ~r_buzzer;
                     OP_CLS:  r_dc <= '0;
`ifdef VERIPAC_CARRY_EN
                     OP_JC:   if (r_carry) r_pc <= r_dc;
`endif
                     default: ;
                  endcase
               end
               default: ;
            endcase
         end
         if (wr && w_hit_cb) begin
            case (3'(w_off_cb))
               // A restart abandons any pending key wait
               CB_CTRL: if (din[0]) begin
                  r_state      <= ST_FETCH1;
                  r_key_wanted <= 1'b0;
               end
               CB_KEY: begin
                  r_kbd         <= din;
                  r_key_pressed <= 1'b1;
               end
               CB_ACC:  r_acc <= din;
               CB_PC:   r_pc <= AW'(din);
               CB_IR:   r_ir <= din;
               CB_DC:   r_dc <= AW'(din);
               default: ;
            endcase
         end
      end
   end

endmodule
